// File: rtl/pcie_dl_fc_init_ctrl.sv
// VC0 flow-control initialization engine: sends InitFC1/InitFC2 DLLP sets,
// captures the link partner's credits and reports fc1/fc2 completion.
module pcie_dl_fc_init_ctrl #(
    parameter logic [7:0]  PH_CREDITS    = 8'd32,
    parameter logic [11:0] PD_CREDITS    = 12'd256,
    parameter logic [7:0]  NPH_CREDITS   = 8'd32,
    parameter logic [11:0] NPD_CREDITS   = 12'd64,
    parameter logic [7:0]  CPLH_CREDITS  = 8'd0,
    parameter logic [11:0] CPLD_CREDITS  = 12'd0,
    parameter int unsigned RESEND_CYCLES = 4250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_flow_control_i,
    input  logic        soft_reset_i,
    input  logic        rx_dllp_valid_i,
    input  logic [7:0]  rx_dllp_type_i,
    input  logic [7:0]  rx_hdr_fc_i,
    input  logic [11:0] rx_data_fc_i,
    output logic        tx_dllp_valid_o,
    input  logic        tx_dllp_ready_i,
    output logic [7:0]  tx_dllp_type_o,
    output logic [7:0]  tx_hdr_fc_o,
    output logic [11:0] tx_data_fc_o,
    output logic        fc1_values_stored_o,
    output logic        fc2_values_stored_o,
    output logic [7:0]  ph_o,
    output logic [7:0]  nph_o,
    output logic [7:0]  cplh_o,
    output logic [11:0] pd_o,
    output logic [11:0] npd_o,
    output logic [11:0] cpld_o
);

    localparam int unsigned TW = $clog2(RESEND_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FC1, ST_FC2, ST_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cap_q, cap_d;
    logic        fc1_q, fc1_d, fc2_q, fc2_d;
    logic        set_seen_q, set_seen_d;
    logic        set_fc2_q, set_fc2_d;
    logic [1:0]  idx_q, idx_d;
    logic        gap_q, gap_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_type_q, tx_type_d, tx_hdr_q, tx_hdr_d;
    logic [11:0] tx_data_q, tx_data_d;
    logic [7:0]  ph_q, ph_d, nph_q, nph_d, cplh_q, cplh_d;
    logic [11:0] pd_q, pd_d, npd_q, npd_d, cpld_q, cpld_d;

    logic        rx_vc0, rx_init, rx_fc2ev;
    logic [1:0]  rx_kind, rx_cls;
    logic        accept, launch, launch_fc2, new_ok;
    logic [1:0]  launch_idx;

    // Type byte: [7:6] kind (01 InitFC1, 11 InitFC2, 10 UpdateFC), [5:4] P/NP/Cpl, [3:0] zero for VC0
    always_comb begin
        rx_kind  = rx_dllp_type_i[7:6];
        rx_cls   = rx_dllp_type_i[5:4];
        rx_vc0   = rx_dllp_valid_i && (rx_dllp_type_i[3:0] == 4'h0) && (rx_cls != 2'b11);
        rx_init  = rx_vc0 && ((rx_kind == 2'b01) || (rx_kind == 2'b11));
        rx_fc2ev = rx_vc0 && ((rx_kind == 2'b11) || (rx_kind == 2'b10));
    end

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        fc1_d      = fc1_q;
        fc2_d      = fc2_q;
        set_seen_d = set_seen_q;
        set_fc2_d  = set_fc2_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        timer_d    = timer_q;
        tx_valid_d = tx_valid_q;
        tx_type_d  = tx_type_q;
        tx_hdr_d   = tx_hdr_q;
        tx_data_d  = tx_data_q;
        ph_d       = ph_q;
        pd_d       = pd_q;
        nph_d      = nph_q;
        npd_d      = npd_q;
        cplh_d     = cplh_q;
        cpld_d     = cpld_q;
        accept     = tx_valid_q && tx_dllp_ready_i;
        launch     = 1'b0;
        launch_idx = 2'd0;
        launch_fc2 = 1'b0;
        new_ok     = 1'b0;

        if (soft_reset_i || !init_flow_control_i) begin
            state_d    = ST_IDLE;
            cap_d      = 3'b000;
            fc1_d      = 1'b0;
            fc2_d      = 1'b0;
            set_seen_d = 1'b0;
            set_fc2_d  = 1'b0;
            idx_d      = 2'd0;
            gap_d      = 1'b0;
            timer_d    = '0;
            tx_valid_d = 1'b0;
            tx_type_d  = 8'h00;
            tx_hdr_d   = 8'h00;
            tx_data_d  = 12'h000;
            ph_d       = 8'h00;
            pd_d       = 12'h000;
            nph_d      = 8'h00;
            npd_d      = 12'h000;
            cplh_d     = 8'h00;
            cpld_d     = 12'h000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FC1;
                    launch  = 1'b1;
                end
                ST_FC1: begin
                    if (rx_init) begin
                        case (rx_cls)
                            2'd0: if (!cap_q[0]) begin
                                cap_d[0] = 1'b1;
                                ph_d     = rx_hdr_fc_i;
                                pd_d     = rx_data_fc_i;
                            end
                            2'd1: if (!cap_q[1]) begin
                                cap_d[1] = 1'b1;
                                nph_d    = rx_hdr_fc_i;
                                npd_d    = rx_data_fc_i;
                            end
                            default: if (!cap_q[2]) begin
                                cap_d[2] = 1'b1;
                                cplh_d   = rx_hdr_fc_i;
                                cpld_d   = rx_data_fc_i;
                            end
                        endcase
                    end
                    fc1_d = &cap_d;
                    if (fc1_q && set_seen_q) state_d = ST_FC2;
                end
                ST_FC2: begin
                    if (rx_fc2ev) begin
                        fc2_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase

            // DLLP set sequencing; a set's type is fixed by the state when its P DLLP launches
            new_ok = (state_d != ST_DONE);
            if (state_q != ST_IDLE) begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == 2'd2) begin
                        gap_d   = 1'b1;
                        timer_d = '0;
                        if (!set_fc2_q) set_seen_d = 1'b1;
                    end else if (new_ok) begin
                        launch     = 1'b1;
                        launch_idx = 2'(idx_q + 2'd1);
                        launch_fc2 = set_fc2_q;
                    end
                end else if (gap_q) begin
                    if ((timer_q == TW'(RESEND_CYCLES - 1)) && new_ok) begin
                        gap_d      = 1'b0;
                        launch     = 1'b1;
                        launch_fc2 = (state_q == ST_FC2);
                    end else if (timer_q < TW'(RESEND_CYCLES)) begin
                        timer_d = TW'(timer_q + TW'(1));
                    end
                end
            end

            if (launch) begin
                tx_valid_d = 1'b1;
                idx_d      = launch_idx;
                set_fc2_d  = launch_fc2;
                tx_type_d  = {(launch_fc2 ? 2'b11 : 2'b01), launch_idx, 4'h0};
                case (launch_idx)
                    2'd0: begin
                        tx_hdr_d  = PH_CREDITS;
                        tx_data_d = PD_CREDITS;
                    end
                    2'd1: begin
                        tx_hdr_d  = NPH_CREDITS;
                        tx_data_d = NPD_CREDITS;
                    end
                    default: begin
                        tx_hdr_d  = CPLH_CREDITS;
                        tx_data_d = CPLD_CREDITS;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cap_q      <= 3'b000;
            fc1_q      <= 1'b0;
            fc2_q      <= 1'b0;
            set_seen_q <= 1'b0;
            set_fc2_q  <= 1'b0;
            idx_q      <= 2'd0;
            gap_q      <= 1'b0;
            timer_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_type_q  <= 8'h00;
            tx_hdr_q   <= 8'h00;
            tx_data_q  <= 12'h000;
            ph_q       <= 8'h00;
            pd_q       <= 12'h000;
            nph_q      <= 8'h00;
            npd_q      <= 12'h000;
            cplh_q     <= 8'h00;
            cpld_q     <= 12'h000;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            fc1_q      <= fc1_d;
            fc2_q      <= fc2_d;
            set_seen_q <= set_seen_d;
            set_fc2_q  <= set_fc2_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            timer_q    <= timer_d;
            tx_valid_q <= tx_valid_d;
            tx_type_q  <= tx_type_d;
            tx_hdr_q   <= tx_hdr_d;
            tx_data_q  <= tx_data_d;
            ph_q       <= ph_d;
            pd_q       <= pd_d;
            nph_q      <= nph_d;
            npd_q      <= npd_d;
            cplh_q     <= cplh_d;
            cpld_q     <= cpld_d;
        end
    end

    assign tx_dllp_valid_o     = tx_valid_q;
    assign tx_dllp_type_o      = tx_type_q;
    assign tx_hdr_fc_o         = tx_hdr_q;
    assign tx_data_fc_o        = tx_data_q;
    assign fc1_values_stored_o = fc1_q;
    assign fc2_values_stored_o = fc2_q;
    assign ph_o                = ph_q;
    assign pd_o                = pd_q;
    assign nph_o               = nph_q;
    assign npd_o               = npd_q;
    assign cplh_o              = cplh_q;
    assign cpld_o              = cpld_q;

endmodule

// File: tb/tb_pcie_dl_fc_init_ctrl.sv
// Directed bench for pcie_dl_fc_init_ctrl: TX set sequencing, resend gap,
// credit capture, FC1->FC2->DONE progression and soft reset.
module tb_pcie_dl_fc_init_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        init, soft_reset;
    logic        rx_valid;
    logic [7:0]  rx_type, rx_hdr;
    logic [11:0] rx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_type, tx_hdr;
    logic [11:0] tx_data;
    logic        fc1, fc2;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    pcie_dl_fc_init_ctrl dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .init_flow_control_i (init),
        .soft_reset_i        (soft_reset),
        .rx_dllp_valid_i     (rx_valid),
        .rx_dllp_type_i      (rx_type),
        .rx_hdr_fc_i         (rx_hdr),
        .rx_data_fc_i        (rx_data),
        .tx_dllp_valid_o     (tx_valid),
        .tx_dllp_ready_i     (tx_ready),
        .tx_dllp_type_o      (tx_type),
        .tx_hdr_fc_o         (tx_hdr),
        .tx_data_fc_o        (tx_data),
        .fc1_values_stored_o (fc1),
        .fc2_values_stored_o (fc2),
        .ph_o                (ph),
        .nph_o               (nph),
        .cplh_o              (cplh),
        .pd_o                (pd),
        .npd_o               (npd),
        .cpld_o              (cpld)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
        rx_valid = 1'b1;
        rx_type  = t;
        rx_hdr   = h;
        rx_data  = d;
        step();
        rx_valid = 1'b0;
        rx_type  = 8'h00;
        rx_hdr   = 8'h00;
        rx_data  = 12'h000;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!tx_valid && cnt < 6000) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; soft_reset = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_type = 8'h00; rx_hdr = 8'h00; rx_data = 12'h000;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_type", 32'(tx_type), 32'h00);
        chk("rst_fc1", 32'(fc1), 32'd0);
        chk("rst_fc2", 32'(fc2), 32'd0);
        chk("rst_ph", 32'(ph), 32'd0);
        chk("rst_pd", 32'(pd), 32'd0);

        // First InitFC1 set, ready always high
        init = 1'b1; tx_ready = 1'b1;
        step();
        chk("p_valid", 32'(tx_valid), 32'd1);
        chk("p_type", 32'(tx_type), 32'h40);
        chk("p_hdr", 32'(tx_hdr), 32'd32);
        chk("p_data", 32'(tx_data), 32'd256);
        step();
        chk("np_type", 32'(tx_type), 32'h50);
        chk("np_hdr", 32'(tx_hdr), 32'd32);
        chk("np_data", 32'(tx_data), 32'd64);
        step();
        chk("cpl_type", 32'(tx_type), 32'h60);
        chk("cpl_hdr", 32'(tx_hdr), 32'd0);
        chk("cpl_data", 32'(tx_data), 32'd0);
        step();
        chk("gap_valid", 32'(tx_valid), 32'd0);
        wait_valid(n);
        chk("gap_len", 32'(n), 32'd4250);
        chk("set2_p_type", 32'(tx_type), 32'h40);

        // Backpressure mid-set
        step();
        chk("set2_np_type", 32'(tx_type), 32'h50);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_type", 32'(tx_type), 32'h50);
            chk("hold_payload", {12'(tx_hdr), tx_data}, {12'd32, 12'd64});
        end
        tx_ready = 1'b1;
        step();
        chk("after_hold_type", 32'(tx_type), 32'h60);
        step();
        chk("set2_gap_valid", 32'(tx_valid), 32'd0);

        // UpdateFC ignored in FC1, then capture during gap
        send(8'h80, 8'd55, 12'd77);
        chk("upd_fc1_ph", 32'(ph), 32'd0);
        send(8'h40, 8'd8, 12'd64);
        chk("cap_ph", 32'(ph), 32'd8);
        chk("cap_pd", 32'(pd), 32'd64);
        chk("cap_fc1_p", 32'(fc1), 32'd0);
        send(8'h50, 8'd4, 12'd0);
        chk("cap_nph", 32'(nph), 32'd4);
        chk("cap_fc1_np", 32'(fc1), 32'd0);
        send(8'h60, 8'd0, 12'd0);
        chk("cap_fc1", 32'(fc1), 32'd1);
        send(8'h40, 8'd99, 12'd1);
        chk("dup_ph", 32'(ph), 32'd8);
        chk("dup_pd", 32'(pd), 32'd64);

        wait_valid(n);
        chk("fc2_set_valid", 32'(tx_valid), 32'd1);
        chk("fc2_set_type", 32'(tx_type), 32'hC0);
        chk("fc2_set_hdr", 32'(tx_hdr), 32'd32);
        step();
        chk("fc2_np_type", 32'(tx_type), 32'hD0);

        // Soft reset while a DLLP is pending in FC2
        tx_ready = 1'b0; soft_reset = 1'b1;
        step();
        chk("srst_valid", 32'(tx_valid), 32'd0);
        chk("srst_type", 32'(tx_type), 32'h00);
        chk("srst_fc1", 32'(fc1), 32'd0);
        chk("srst_ph", 32'(ph), 32'd0);
        chk("srst_pd", 32'(pd), 32'd0);
        soft_reset = 1'b0; tx_ready = 1'b1;
        step();
        chk("restart_valid", 32'(tx_valid), 32'd1);
        chk("restart_type", 32'(tx_type), 32'h40);

        // Capture during the first set; InitFC2 counts for FC1 only
        send(8'h40, 8'd10, 12'd20);
        chk("r_np_type", 32'(tx_type), 32'h50);
        chk("r_ph", 32'(ph), 32'd10);
        chk("r_pd", 32'(pd), 32'd20);
        send(8'hD0, 8'd5, 12'd6);
        chk("r_cpl_type", 32'(tx_type), 32'h60);
        chk("r_nph_npd", {12'(nph), npd}, {12'd5, 12'd6});
        chk("r_fc1_early", 32'(fc1), 32'd0);
        send(8'h60, 8'd1, 12'd2);
        chk("r_gap_valid", 32'(tx_valid), 32'd0);
        chk("r_fc1", 32'(fc1), 32'd1);
        chk("r_cpl_cap", {12'(cplh), cpld}, {12'd1, 12'd2});
        chk("r_fc2_from_initfc2_in_fc1", 32'(fc2), 32'd0);
        send(8'h40, 8'd77, 12'd0);
        chk("r_fc2_initfc1", 32'(fc2), 32'd0);
        send(8'hC1, 8'd0, 12'd0);
        chk("r_fc2_vc1", 32'(fc2), 32'd0);
        send(8'h40, 8'd78, 12'd0);
        chk("r_fc2_initfc1_in_fc2", 32'(fc2), 32'd0);
        chk("r_frozen_ph", 32'(ph), 32'd10);

        wait_valid(n);
        chk("r_fc2_set_valid", 32'(tx_valid), 32'd1);
        chk("r_fc2_set_type", 32'(tx_type), 32'hC0);

        // UpdateFC completes FC2 while the P DLLP is still pending
        tx_ready = 1'b0;
        send(8'h80, 8'd3, 12'd3);
        chk("done_fc2", 32'(fc2), 32'd1);
        chk("done_inflight_valid", 32'(tx_valid), 32'd1);
        chk("done_inflight_type", 32'(tx_type), 32'hC0);
        chk("done_frozen_ph", 32'(ph), 32'd10);
        step();
        chk("done_hold_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        step();
        chk("done_valid_drop", 32'(tx_valid), 32'd0);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (tx_valid) n++;
        end
        chk("done_no_more_valid", 32'(n), 32'd0);
        chk("done_fc2_held", 32'(fc2), 32'd1);

        init = 1'b0;
        step();
        chk("deinit_fc2", 32'(fc2), 32'd0);
        chk("deinit_fc1", 32'(fc1), 32'd0);
        chk("deinit_ph", 32'(ph), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
